// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU datapath blocks.
//   adder_state_t : control states of the serial adder (IDLE, RUN, DONE)
//   OP_ADD/OP_SUB : encoding of the add/subtract select input
//   calcSteps()   : number of digit steps for a WIDTH/DIGIT pair; returns 0
//                   for an illegal pairing so callers can refuse to elaborate
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} adder_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // A zero result flags an unusable geometry: too narrow, or a digit size
  // that does not tile the operand exactly.
  function automatic int calcSteps(input int width, input int digit);
    if (width < 2 || digit < 1 || digit > width || (width % digit) != 0) begin
      return 0;
    end
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// ---------------------------------------------------------------------------
// digit_adder
// Combinational DIGIT-bit ripple-carry slice.
//   a_i, b_i     : DIGIT-bit addends
//   cin_i        : carry into bit 0
//   s_o          : DIGIT-bit sum
//   cout_o       : carry out of the top bit
//   msb_cin_o    : carry into the top bit (needed for signed overflow)
// ---------------------------------------------------------------------------
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] s_o,
  output logic             cout_o,
  output logic             msb_cin_o
);

  logic [DIGIT:0] carries;

  // Plain ripple chain; carries[i] is the carry entering bit i.
  always_comb begin
    carries    = '0;
    s_o        = '0;
    carries[0] = cin_i;
    for (int i = 0; i < DIGIT; i++) begin
      s_o[i]       = a_i[i] ^ b_i[i] ^ carries[i];
      carries[i+1] = (a_i[i] & b_i[i]) | (carries[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o    = carries[DIGIT];
  assign msb_cin_o = carries[DIGIT-1];

endmodule

// File: rtl/serial_adder_nbit.sv
// ---------------------------------------------------------------------------
// serial_adder_nbit
// Multi-cycle add/subtract unit processing WIDTH-bit operands DIGIT bits per
// clock, with a start/busy/done handshake and registered result flags.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start_i      : request an operation (sampled in IDLE or DONE only)
//   sub_i        : 0 = a+b, 1 = a-b (sampled with start_i)
//   a_i, b_i     : WIDTH-bit operands (sampled with start_i)
//   busy_o       : high while digits are being processed
//   done_o       : one-cycle pulse when the results become valid
//   sum_o        : WIDTH-bit result, modulo 2^WIDTH
//   carry_out_o  : final carry (no-borrow for subtract)
//   overflow_o   : two's-complement overflow
//   zero_o       : sum_o == 0
// ---------------------------------------------------------------------------
module serial_adder_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int STEPS = calcSteps(WIDTH, DIGIT);
  localparam int CNT_W = $clog2(STEPS + 1);

  if (STEPS == 0) begin : gIllegalGeometry
    $fatal(1, "serial_adder_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  adder_state_t     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carryOut_q, carryOut_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0]       sliceSum;
  logic                   sliceCout;
  logic                   sliceMsbCin;
  logic [WIDTH+DIGIT-1:0] shiftCat;
  logic [WIDTH-1:0]       partialNext;
  logic                   lastStep;

  digit_adder #(
    .DIGIT(DIGIT)
  ) uDigitAdder (
    .a_i      (opA_q[DIGIT-1:0]),
    .b_i      (opB_q[DIGIT-1:0]),
    .cin_i    (carry_q),
    .s_o      (sliceSum),
    .cout_o   (sliceCout),
    .msb_cin_o(sliceMsbCin)
  );

  // New digits enter at the top so that after STEPS shifts the first digit
  // has reached bit 0; the concatenation avoids an empty slice when
  // DIGIT == WIDTH.
  assign shiftCat    = {sliceSum, partial_q};
  assign partialNext = shiftCat[WIDTH+DIGIT-1:DIGIT];
  assign lastStep    = (count_q == CNT_W'(STEPS - 1));

  // Next-state and datapath update. Subtraction is a + ~b + 1, with the +1
  // supplied as the initial carry. Result registers only change on the
  // final digit, so they never expose a partial value.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    carry_d    = carry_q;
    partial_d  = partial_q;
    sum_d      = sum_q;
    carryOut_d = carryOut_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = RUN;
          opA_d     = a_i;
          opB_d     = (sub_i == OP_SUB) ? ~b_i : b_i;
          carry_d   = sub_i;
          count_d   = '0;
          partial_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        partial_d = partialNext;
        opA_d     = opA_q >> DIGIT;
        opB_d     = opB_q >> DIGIT;
        carry_d   = sliceCout;
        count_d   = count_q + CNT_W'(1);
        if (lastStep) begin
          state_d    = DONE;
          sum_d      = partialNext;
          carryOut_d = sliceCout;
          overflow_d = sliceMsbCin ^ sliceCout;
          zero_d     = (partialNext == '0);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state, including the visible result flags, clears on reset so an
  // interrupted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      carry_q    <= 1'b0;
      partial_q  <= '0;
      sum_q      <= '0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      carry_q    <= carry_d;
      partial_q  <= partial_d;
      sum_q      <= sum_d;
      carryOut_q <= carryOut_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
  assign sum_o       = sum_q;
  assign carry_out_o = carryOut_q;
  assign overflow_o  = overflow_q;
  assign zero_o      = zero_q;

endmodule

// File: doc/serial_adder_nbit.md
# serial_adder_nbit

Multi-cycle, parametrised add/subtract unit that processes WIDTH-bit operands DIGIT bits per clock, with a start/busy/done handshake and registered status flags. It is the area-saving, sequential successor to the team's combinational single-bit adder cell. It sits under the ALU controller, which issues one operation at a time and waits for `done`.

## Interface
- `WIDTH`, default 8: operand and result width. Must be at least 2.
- `DIGIT`, default 1: bits processed per cycle. `WIDTH % DIGIT` must equal 0; elaboration fails otherwise.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request an operation. Sampled only in IDLE or DONE.
- `sub` input, 1 bit: 0 selects a+b, 1 selects a-b. Sampled with `start`.
- `a` input, WIDTH bits: operand A. Sampled with `start`.
- `b` input, WIDTH bits: operand B. Sampled with `start`.
- `busy` output, 1 bit: operation in progress. High in RUN.
- `done` output, 1 bit: one-cycle pulse when the results are valid.
- `sum` output, WIDTH bits: result.
- `carry_out` output, 1 bit: adder carry. For sub it means no-borrow (a ≥ b unsigned).
- `overflow` output, 1 bit: two's-complement overflow.
- `zero` output, 1 bit: `sum` == 0.

## Operation
- STEPS = WIDTH/DIGIT. The cycle counter is $clog2(STEPS+1) bits wide.
- FSM states:
  - IDLE → RUN on `start`.
  - RUN stays for STEPS cycles, then → DONE.
  - DONE → RUN if `start`, else → IDLE.
  - `start` is ignored in RUN and has no side effect.
- Accepting `start`:
  - Latch A = `a`.
  - Latch B = `sub` ? ~`b` : `b`.
  - carry = `sub`.
  - Clear the counter and the partial result.
- Each RUN cycle:
  - Add the low DIGIT bits of A and B plus carry.
  - Shift the DIGIT-bit result into the top of the partial-result register.
  - Shift A and B right by DIGIT.
  - Update carry and increment the counter.
- On the last RUN cycle:
  - `sum` = the completed partial result.
  - `carry_out` = final carry.
  - `overflow` = carry into the MSB XOR carry out of the MSB. When DIGIT > 1, take the MSB carry-in from inside the slice.
  - `zero` = (`sum` == 0).
  - All four are registered together.
- Result outputs hold their value until the next completion. They never show partial values.
- Arithmetic is modulo 2^WIDTH.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - State = IDLE.
  - `busy` = 0, `done` = 0, `sum` = 0, `carry_out` = 0, `overflow` = 0, `zero` = 0. `zero` resets to 0, not 1.
  - Internal registers are cleared.
  - Any in-flight operation is discarded; no `done` is produced.
- Edge E0 accepts `start`. `busy` reads 1 from after E0 until E_STEPS.
- Edges E1..E_STEPS each process one digit.
- After E_STEPS:
  - `done` = 1 for exactly one cycle and `busy` = 0.
  - Results are valid in that cycle and stay valid afterwards.
- Latency from the accepting edge to `done`: STEPS cycles.
- Back-to-back: `start` held high during the DONE cycle is accepted at that edge. Throughput is one operation per STEPS+1 cycles.
- `start` held high continuously causes back-to-back operations. `done` pulses once per operation.

## Structure
- Shared package `alu_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} adder_state_t;`
  - `localparam` `OP_ADD` = 1'b0 and `OP_SUB` = 1'b1.
  - A function computing STEPS with a width-legality check.
- Sub-module `digit_adder`:
  - Combinational DIGIT-bit ripple slice.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and msb_cin (carry into the top bit).
  - Instantiated once by `serial_adder_nbit`.
- The top level holds the FSM, counter, shift registers and flag registers only.

## Test plan
- WIDTH=8, DIGIT=1, add 0x7F+0x01 → `sum`=0x80, `overflow`=1, `carry_out`=0, `zero`=0. `done` arrives exactly 8 cycles after the accepting edge.
- Add 0xFF+0x01 → `sum`=0x00, `carry_out`=1, `zero`=1, `overflow`=0.
- Sub 0x05-0x07 → `sum`=0xFE, `carry_out`=0, `overflow`=0.
- Sub 0x80-0x01 → `sum`=0x7F, `carry_out`=1, `overflow`=1.
- `start` pulsed mid-RUN with different operands → ignored, and the original result is returned.
- `rst_n` asserted at cycle 4 of RUN → all outputs 0 and no `done`.
- WIDTH=8, DIGIT=4: add 0x9C+0x64 → `sum`=0x00, `carry_out`=1, `zero`=1, `done` 2 cycles after start.
- Back-to-back `start` in the DONE cycle → second `done` 9 cycles after the first.
- Random regression against a reference model: WIDTH ∈ {4, 8, 16}, all legal DIGIT values, 10k operations each, all flags checked.
